// File: rtl/mul_issue_ctrl_pkg.sv
// Shared definitions for the Booth multiplier issue controller:
// FSM state encoding and default sizing parameters.
package mul_issue_ctrl_pkg;

   localparam int WIDTH_DEF     = 32;
   localparam int MUL_STEPS_DEF = 32;
   localparam int QDEPTH_DEF    = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_WAIT  = 3'd2,
      ST_CAPT  = 3'd3,
      ST_HOLD  = 3'd4
   } state_e;

endpackage

// File: rtl/op_fifo.sv
// Small synchronous FIFO holding operand pairs ahead of the multiplier.
// Head entry is presented combinationally; simultaneous push and pop
// both take effect and leave the occupancy unchanged.
module op_fifo
   import mul_issue_ctrl_pkg::*;
#(
   parameter int DW    = 64,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   output logic [DW-1:0] pop_data_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic          push_ok;
   logic          pop_ok;

   // Pointer advance with explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1);
      end
   endfunction

   assign full_o     = (cnt_q == CW'(DEPTH));
   assign empty_o    = (cnt_q == {CW{1'b0}});
   assign pop_data_o = mem_q[rd_ptr_q];

   // Qualify requests against the current occupancy.
   always_comb begin
      push_ok = push_i && !full_o;
      pop_ok  = pop_i && !empty_o;
   end

   // Storage, pointers and occupancy count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DW{1'b0}};
         end
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         cnt_q    <= {CW{1'b0}};
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_ok) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller for an external Booth multiplier: queues operand pairs,
// launches one multiplication at a time, counts the step cycles and
// captures the product into a held result register.
module mul_issue_ctrl
   import mul_issue_ctrl_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int MUL_STEPS = MUL_STEPS_DEF,
   parameter int QDEPTH    = QDEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [WIDTH-1:0]   req_mc,
   input  logic [WIDTH-1:0]   req_mp,
   output logic [WIDTH-1:0]   mul_mc,
   output logic [WIDTH-1:0]   mul_mp,
   output logic               mul_start,
   input  logic [2*WIDTH-1:0] mul_prod,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2*WIDTH-1:0] res_data,
   output logic               idle
);

   localparam int CNT_W = $clog2(MUL_STEPS + 1);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic [WIDTH-1:0]   mul_mc_q;
   logic [WIDTH-1:0]   mul_mp_q;
   logic               mul_start_q;
   logic               res_valid_q;
   logic [2*WIDTH-1:0] res_data_q;

   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [2*WIDTH-1:0] fifo_head;

   op_fifo #(
      .DW    (2 * WIDTH),
      .DEPTH (QDEPTH)
   ) u_op_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (fifo_push),
      .push_data_i ({req_mc, req_mp}),
      .pop_i       (fifo_pop),
      .pop_data_o  (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Queue handshake, pop request and step-counter increment.
   always_comb begin
      fifo_push = req_valid && !fifo_full;
      fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
      cnt_d     = cnt_q + CNT_W'(1);
   end

   // Operation sequencer; every output is a register written here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         mul_mc_q    <= {WIDTH{1'b0}};
         mul_mp_q    <= {WIDTH{1'b0}};
         mul_start_q <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= {(2*WIDTH){1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  // Operands stay latched until the next pop.
                  mul_mc_q    <= fifo_head[2*WIDTH-1:WIDTH];
                  mul_mp_q    <= fifo_head[WIDTH-1:0];
                  mul_start_q <= 1'b1;
                  state_q     <= ST_START;
               end else begin
                  mul_start_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            ST_START: begin
               mul_start_q <= 1'b0;
               cnt_q       <= {CNT_W{1'b0}};
               state_q     <= ST_WAIT;
            end
            ST_WAIT: begin
               // Counter is one bit wider than needed for MUL_STEPS-1, so the
               // final increment on exit cannot wrap.
               cnt_q <= cnt_d;
               if (cnt_q == CNT_W'(MUL_STEPS - 1)) begin
                  state_q <= ST_CAPT;
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            ST_CAPT: begin
               // The only cycle in which the product bus is sampled.
               res_data_q  <= mul_prod;
               res_valid_q <= 1'b1;
               state_q     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end else begin
                  state_q     <= ST_HOLD;
               end
            end
            default: begin
               mul_start_q <= 1'b0;
               res_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready = !fifo_full;
   assign mul_mc    = mul_mc_q;
   assign mul_mp    = mul_mp_q;
   assign mul_start = mul_start_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign idle      = (state_q == ST_IDLE) && fifo_empty;

endmodule

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand width in bits.
REQ-002 SHALL have parameter MUL_STEPS, default 32, the number of multiplier step cycles between the start pulse and a valid product.
REQ-003 SHALL have parameter QDEPTH, default 2, the operand-queue depth in entries.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req_valid  input  1  the upstream operand pair is valid.
REQ-007 req_ready  output  1  the queue can accept a pair.
REQ-008 req_mc  input  WIDTH  multiplicand, two's complement.
REQ-009 req_mp  input  WIDTH  multiplier, two's complement.
REQ-010 mul_mc  output  WIDTH  registered multiplicand driven to the Booth multiplier.
REQ-011 mul_mp  output  WIDTH  registered multiplier operand driven to the Booth multiplier.
REQ-012 mul_start  output  1  load pulse to the Booth multiplier.
REQ-013 mul_prod  input  2*WIDTH  product bus from the Booth multiplier.
REQ-014 res_valid  output  1  res_data holds a product.
REQ-015 res_ready  input  1  the downstream consumer takes the product.
REQ-016 res_data  output  2*WIDTH  captured signed product.
REQ-017 idle  output  1  the FSM is in IDLE and the queue is empty.

Function
REQ-018 A request transfers on a rising edge when req_valid and req_ready are both high; req_ready SHALL equal "queue not full".
REQ-019 The queue SHALL be FIFO-ordered; a push and a pop in the same cycle SHALL both take effect, with the count unchanged.
REQ-020 The FSM SHALL have exactly the states IDLE, START, WAIT, CAPT and HOLD.
REQ-021 IDLE with the queue non-empty: pop the head into mul_mc/mul_mp, then go to START; otherwise stay in IDLE.
REQ-022 START: mul_start=1 for exactly this one cycle, load step counter with 0, then go to WAIT; mul_start SHALL be 0 in every other state.
REQ-023 WAIT: increment the counter each cycle; when the counter equals MUL_STEPS-1, go to CAPT.
REQ-024 CAPT: register mul_prod into res_data, set res_valid, then go to HOLD.
REQ-025 HOLD: when res_ready is high, clear res_valid and go to IDLE; res_data and res_valid SHALL stay stable while res_ready is low.
REQ-026 mul_mc/mul_mp SHALL hold their values from the pop until the next pop.
REQ-027 Latency with an empty queue and FSM in IDLE: res_valid SHALL rise after the 35th rising edge following the request handshake edge (MUL_STEPS+3).
REQ-028 While the FSM is busy, up to QDEPTH further requests SHALL be accepted; the next pop SHALL occur in the IDLE cycle following a HOLD exit.
REQ-029 The step counter SHALL be $clog2(MUL_STEPS+1) bits wide and SHALL never wrap within one operation.
REQ-030 mul_prod SHALL be ignored outside CAPT; the multiplier free-running after step MUL_STEPS SHALL NOT affect res_data.

Reset
REQ-031 On rst: state=IDLE, queue empty, req_ready=1, mul_start=0, mul_mc=0, mul_mp=0, res_valid=0, res_data=0, counter=0, idle=1.
REQ-032 Reset asserted mid-operation SHALL abort the operation and discard queued pairs; no partial result SHALL appear after release.

Structure
REQ-033 The FSM state encoding and the MUL_STEPS default SHALL live in a shared package used by both the controller and the bench.
REQ-034 The operand queue SHALL be a sub-module, op_fifo, parameterised by entry width (2*WIDTH) and QDEPTH, with full/empty outputs.
REQ-035 The controller SHALL contain no arithmetic other than the step counter and the queue pointers.

Verification
REQ-036 Reset, then one request mc=30, mp=13, res_ready=1 -> res_data=390, res_valid high one cycle, 35 edges after the handshake.
REQ-037 mc=-7, mp=6 -> res_data=0xFFFFFFFFFFFFFFD6.
REQ-038 mc=mp=0x7FFFFFFF -> res_data=0x3FFFFFFF00000001.
REQ-039 Three back-to-back requests (2x3, 4x5, 6x7) with res_ready low for 10 cycles on the first result -> req_ready low after two queued pairs; outputs 6, 20, 42 in order; res_data stable while stalled.
REQ-040 Assert rst at WAIT counter=10 with one pair queued -> all outputs at reset values next cycle; no res_valid for 100 cycles after release.
